// File: rtl/pico_bus_fabric.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pico_bus_fabric                                               |
// | Brief    : picorv32 native-bus decoder, wait-state generator, read mux.  |
// |            Optional timeout/error capture: define BUS_TIMEOUT_EN.        |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module pico_bus_fabric #(
    parameter int          NSLV    = 8,
    parameter logic [63:0] SLV_LAT = {16{4'd1}},
    parameter int          TIMEOUT = 255
) (
    input  logic               clk24,
    input  logic               reset,
    input  logic               mem_valid,
    input  logic [31:0]        mem_addr,
    input  logic [31:0]        mem_wdata,
    input  logic [3:0]         mem_wstrb,
    output logic               mem_ready,
    output logic [31:0]        mem_rdata,
    output logic [NSLV-1:0]    s_sel,
    output logic [31:0]        s_addr,
    output logic [31:0]        s_wdata,
    output logic [3:0]         s_wstrb,
    input  logic [32*NSLV-1:0] s_rdata,
    input  logic [NSLV-1:0]    s_ready,
    output logic               bus_err,
    output logic [31:0]        err_addr,
    input  logic               err_clr
);

    localparam logic [4:0]  c_nslv      = 5'(NSLV);
    localparam logic [31:0] c_err_rdata = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_idx, w_idx_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic        r_hs, w_hs_nxt;
    logic        r_unmap, w_unmap_nxt;

    logic [3:0]  w_req_idx;
    logic [3:0]  w_req_lat;
    logic        w_req_mapped;
    logic [3:0]  w_cur_idx;
    logic        w_cur_mapped;
    logic [15:0] w_dec;
    logic [15:0] w_rdy_pad;
    logic [31:0] w_rd_arr [16];
    logic        w_timer_hit;
    logic        w_timeout;

    assign w_req_idx    = mem_addr[31:28];
    assign w_req_lat    = SLV_LAT[{w_req_idx, 2'b00} +: 4];
    assign w_req_mapped = ({1'b0, w_req_idx} < c_nslv);
    assign w_cur_idx    = (r_state == ST_IDLE) ? w_req_idx : r_idx;
    assign w_cur_mapped = ({1'b0, w_cur_idx} < c_nslv);
    assign w_dec        = 16'd1 << w_cur_idx;
    assign w_rdy_pad    = 16'(s_ready);

    // Pad read data to 16 entries so unmapped indices read as zero.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_rd
            if (gi < NSLV) begin : g_map
                assign w_rd_arr[gi] = s_rdata[32*gi +: 32];
            end else begin : g_nomap
                assign w_rd_arr[gi] = 32'h0;
            end
        end
    endgenerate

    always_ff @(posedge clk24) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_idx   <= 4'd0;
            r_cnt   <= 4'd0;
            r_hs    <= 1'b0;
            r_unmap <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hs    <= w_hs_nxt;
            r_unmap <= w_unmap_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_hs_nxt    = r_hs;
        w_unmap_nxt = r_unmap;
        case (r_state)
            ST_IDLE: begin
                if (mem_valid) begin
                    w_idx_nxt   = w_req_idx;
                    w_unmap_nxt = !w_req_mapped;
                    w_hs_nxt    = w_req_mapped && (w_req_lat == 4'd0);
                    w_cnt_nxt   = 4'd0;
                    if (!w_req_mapped) begin
                        w_state_nxt = ST_ACK;
                    end else if (w_req_lat == 4'd0) begin
                        w_state_nxt = w_rdy_pad[w_req_idx] ? ST_ACK : ST_WAIT;
                    end else if (w_req_lat > 4'd1) begin
                        w_cnt_nxt   = w_req_lat - 4'd1;
                        w_state_nxt = ST_WAIT;
                    end else begin
                        w_state_nxt = ST_ACK;
                    end
                end
            end
            ST_WAIT: begin
                if (!mem_valid) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_hs) begin
                    if (w_rdy_pad[r_idx] || w_timer_hit) begin
                        w_state_nxt = ST_ACK;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        w_state_nxt = ST_ACK;
                    end
                end
            end
            ST_ACK:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

`ifdef BUS_TIMEOUT_EN
    logic [15:0] r_timer;
    logic        r_timeout;
    logic        r_bus_err;
    logic [31:0] r_err_addr;
    logic        w_err_event;

    assign w_timer_hit = (r_timer == 16'(TIMEOUT - 1));
    assign w_timeout   = r_timeout;
    // Error sources: unmapped request in cycle 0, or handshake timer expiry.
    assign w_err_event = mem_valid &&
                         (((r_state == ST_IDLE) && !w_req_mapped) ||
                          ((r_state == ST_WAIT) && r_hs && !w_rdy_pad[r_idx] && w_timer_hit));

    always_ff @(posedge clk24) begin
        if (reset) begin
            r_timer   <= 16'd0;
            r_timeout <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            r_timer   <= 16'd0;
            r_timeout <= 1'b0;
        end else if ((r_state == ST_WAIT) && r_hs) begin
            r_timer <= r_timer + 16'd1;
            if (w_timer_hit && !w_rdy_pad[r_idx]) begin
                r_timeout <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk24) begin
        if (reset || err_clr) begin
            r_bus_err  <= 1'b0;
            r_err_addr <= 32'h0;
        end else if (w_err_event && !r_bus_err) begin
            r_bus_err  <= 1'b1;
            r_err_addr <= mem_addr;
        end
    end

    assign bus_err  = r_bus_err;
    assign err_addr = r_err_addr;
`else
    logic w_unused_clr;

    assign w_timer_hit  = 1'b0;
    assign w_timeout    = 1'b0;
    assign bus_err      = 1'b0;
    assign err_addr     = 32'h0;
    assign w_unused_clr = err_clr;
`endif

    assign s_addr    = mem_addr;
    assign s_wdata   = mem_wdata;
    assign s_wstrb   = ((r_state == ST_IDLE) && mem_valid && !reset) ? mem_wstrb : 4'h0;
    assign s_sel     = (mem_valid && w_cur_mapped && !reset) ? w_dec[NSLV-1:0] : '0;
    assign mem_ready = (r_state == ST_ACK) && mem_valid && !reset;

    always_comb begin
        mem_rdata = 32'h0;
        if (mem_ready) begin
            if (w_timeout) begin
                mem_rdata = c_err_rdata;
            end else if (!r_unmap) begin
                mem_rdata = w_rd_arr[r_idx];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pico_bus_fabric.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_pico_bus_fabric                                            |
// | Brief    : Scoreboard bench for pico_bus_fabric (8 slaves, mixed latency)|
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_pico_bus_fabric;

    localparam int          NSLV = 8;
    // Slave latencies: s0=1 s1=1 s2=4 s3=handshake s4=8 s5=2 s6=1 s7=1
    localparam logic [63:0] LAT  = 64'h1111_1111_1128_0411;
    localparam int          TMO  = 16;

    logic              clk24     = 1'b0;
    logic              reset     = 1'b1;
    logic              mem_valid = 1'b0;
    logic [31:0]       mem_addr  = 32'h0;
    logic [31:0]       mem_wdata = 32'h0;
    logic [3:0]        mem_wstrb = 4'h0;
    logic              mem_ready;
    logic [31:0]       mem_rdata;
    logic [NSLV-1:0]   s_sel;
    logic [31:0]       s_addr;
    logic [31:0]       s_wdata;
    logic [3:0]        s_wstrb;
    logic [32*NSLV-1:0] s_rdata = '0;
    logic [NSLV-1:0]   s_ready  = '0;
    logic              bus_err;
    logic [31:0]       err_addr;
    logic              err_clr  = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int tb_cyc   = 0;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        int          lat;
    } exp_t;
    exp_t sb_q[$];

    pico_bus_fabric #(
        .NSLV    (NSLV),
        .SLV_LAT (LAT),
        .TIMEOUT (TMO)
    ) dut (
        .clk24     (clk24),
        .reset     (reset),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .s_sel     (s_sel),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_rdata   (s_rdata),
        .s_ready   (s_ready),
        .bus_err   (bus_err),
        .err_addr  (err_addr),
        .err_clr   (err_clr)
    );

    always #5 clk24 = ~clk24;
    always @(posedge clk24) tb_cyc = tb_cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_val(input int i);
        return (i == 0) ? 32'h1234_5678 : (32'hC0DE_0000 + 32'(i) * 32'h111);
    endfunction

    // Scoreboard consumer: every ready pulse must match the oldest expectation.
    always @(negedge clk24) begin
        if (mem_ready) begin
            if (sb_q.size() == 0) begin
                check_val("spurious_ready", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_val({e.tag, "_rdata"}, mem_rdata, e.rdata);
                check_val({e.tag, "_lat"}, 32'(tb_cyc), 32'(e.lat));
            end
        end
    end

    task automatic do_xfer(input logic [31:0] addr, input logic [3:0] wstrb,
                           input logic [31:0] exp_rdata, input int exp_lat,
                           input int rdy_at, input logic [NSLV-1:0] exp_sel,
                           input string tag);
        bit got;
        @(posedge clk24); #1;
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = ~addr;
        mem_wstrb = wstrb;
        tb_cyc    = 0;
        s_ready   = (rdy_at == 0) ? 8'h08 : 8'h00;
        sb_q.push_back('{tag, exp_rdata, exp_lat});
        @(negedge clk24);
        check_val({tag, "_sel0"}, 32'(s_sel), 32'(exp_sel));
        check_val({tag, "_wstrb0"}, 32'(s_wstrb), 32'(wstrb));
        check_val({tag, "_saddr"}, s_addr, addr);
        got = 1'b0;
        for (int n = 0; n < 60 && !got; n++) begin
            @(posedge clk24); #1;
            if (rdy_at > 0 && tb_cyc == rdy_at) s_ready = 8'h08;
            @(negedge clk24);
            if (tb_cyc == 1) check_val({tag, "_wstrb1"}, 32'(s_wstrb), 32'd0);
            if (mem_ready) begin
                got = 1'b1;
                check_val({tag, "_selack"}, 32'(s_sel), 32'(exp_sel));
            end
        end
        if (!got) begin
            check_val({tag, "_noready"}, 32'd0, 32'd1);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
        end
        @(posedge clk24); #1;
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        s_ready   = 8'h00;
        @(negedge clk24);
        check_val({tag, "_pulse"}, 32'(mem_ready), 32'd0);
    endtask

    initial begin
        int seen;
        for (int i = 0; i < NSLV; i++) s_rdata[32*i +: 32] = rd_val(i);
        repeat (3) @(posedge clk24);
        @(negedge clk24);
        check_val("rst_ready", 32'(mem_ready), 32'd0);
        check_val("rst_sel", 32'(s_sel), 32'd0);
        check_val("rst_rdata", mem_rdata, 32'd0);
        check_val("rst_err", 32'(bus_err), 32'd0);
        check_val("rst_erraddr", err_addr, 32'd0);
        @(posedge clk24); #1;
        reset = 1'b0;

        do_xfer(32'h0000_0010, 4'h0, 32'h1234_5678, 1, -1, 8'h01, "rd_s0");
        do_xfer(32'h2000_0000, 4'hF, rd_val(2),     4, -1, 8'h04, "wr_s2");
        do_xfer(32'h3000_0000, 4'h0, rd_val(3),     7,  6, 8'h08, "hs_late");
        do_xfer(32'h3000_0004, 4'h0, rd_val(3),     1,  0, 8'h08, "hs_now");
        do_xfer(32'h5000_0000, 4'h3, rd_val(5),     2, -1, 8'h20, "s5_l2");
        do_xfer(32'h4000_0000, 4'h0, rd_val(4),     8, -1, 8'h10, "s4_l8");
        do_xfer(32'h7000_0000, 4'h0, rd_val(7),     1, -1, 8'h80, "s7_top");
        do_xfer(32'hF000_0000, 4'h0, 32'h0,         1, -1, 8'h00, "unmap_f");
`ifdef BUS_TIMEOUT_EN
        check_val("err_set", 32'(bus_err), 32'd1);
        check_val("err_addr_f", err_addr, 32'hF000_0000);
        do_xfer(32'h3000_0040, 4'h0, 32'hDEAD_BEEF, 17, -1, 8'h08, "tmo");
        check_val("err_first_kept", err_addr, 32'hF000_0000);
        @(posedge clk24); #1; err_clr = 1'b1;
        @(posedge clk24); #1; err_clr = 1'b0;
        @(negedge clk24);
        check_val("err_clr", 32'(bus_err), 32'd0);
        check_val("err_clr_addr", err_addr, 32'd0);
        err_clr = 1'b1;
        do_xfer(32'h8000_0000, 4'h0, 32'h0, 1, -1, 8'h00, "unmap_8clr");
        err_clr = 1'b0;
        check_val("err_clr_prio", 32'(bus_err), 32'd0);
        do_xfer(32'h9000_0000, 4'h0, 32'h0, 1, -1, 8'h00, "unmap_9");
        check_val("err_addr_9", err_addr, 32'h9000_0000);
`else
        check_val("err_off", 32'(bus_err), 32'd0);
        do_xfer(32'h8000_0000, 4'h0, 32'h0, 1, -1, 8'h00, "unmap_8");
        check_val("erraddr_off", err_addr, 32'd0);
`endif

        // Abort: drop mem_valid in WAIT, then a fresh access must see full latency.
        @(posedge clk24); #1;
        mem_valid = 1'b1; mem_addr = 32'h4000_0020; tb_cyc = 0;
        repeat (3) @(posedge clk24);
        #1 mem_valid = 1'b0;
        do_xfer(32'h4000_0024, 4'h0, rd_val(4), 8, -1, 8'h10, "post_abort");

        // Reset pulsed in WAIT of a write to the L=8 slave.
        @(posedge clk24); #1;
        mem_valid = 1'b1; mem_addr = 32'h4000_0100; mem_wstrb = 4'hF; tb_cyc = 0;
        @(negedge clk24);
        check_val("rstw_wstrb0", 32'(s_wstrb), 32'hF);
        repeat (3) @(posedge clk24);
        #1 reset = 1'b1;
        @(negedge clk24);
        check_val("rstw_ready", 32'(mem_ready), 32'd0);
        check_val("rstw_wstrb", 32'(s_wstrb), 32'd0);
        @(posedge clk24); #1;
        reset = 1'b0; mem_valid = 1'b0; mem_wstrb = 4'h0;
        seen = 0;
        repeat (12) begin
            @(negedge clk24);
            seen += int'(mem_ready) + int'(s_wstrb != 4'h0);
        end
        check_val("rstw_quiet", 32'(seen), 32'd0);
        check_val("rstw_err", 32'(bus_err), 32'd0);
        do_xfer(32'h4000_0200, 4'h1, rd_val(4), 8, -1, 8'h10, "post_rst");

        repeat (3) @(negedge clk24);
        check_val("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
